byte_serializer: RTL and testbench
==================================

// Module: byte_serializer
// PURPOSE
//  Byte-to-bitstream converter. It accepts an 8-bit word over a valid/ready handshake and emits it one bit per accepted beat.
//  It is the sequencing stage that drives the select input of an 8:1 bit mux: an FSM and a 3-bit index counter walk the select.
//  Sits between a byte-wide producer (register file / adder result) and a 1-bit serial consumer (shift link, LED/pin driver).
// PARAMETERS
//  LSB_FIRST   1    1: bit0 sent first, index counts 0->7; 0: bit7 first, index counts 7->0
//  IDLE_LEVEL  1'b0 value driven on ser_out whenever ser_valid=0
// PORTS
//  clk        in   1  single clock, all state updates on posedge
//  rst        in   1  synchronous, active-high reset
//  in_data    in   8  parallel byte to serialize
//  in_valid   in   1  producer has a byte on in_data
//  in_ready   out  1  byte captured on clk edge where in_valid&in_ready
//  ser_out    out  1  current serial bit
//  ser_valid  out  1  ser_out holds a valid bit
//  ser_ready  in   1  consumer takes bit on clk edge where ser_valid&ser_ready
//  ser_last   out  1  current bit is the 8th bit of the byte
//  busy       out  1  FSM in SHIFT state
// BEHAVIOUR
//  Reset (rst=1 at a posedge):
//   - state=IDLE, byte_reg=8'h00, idx=(LSB_FIRST?0:7)
//   - ser_valid=0, ser_last=0, busy=0, ser_out=IDLE_LEVEL
//   - in_ready forced 0 while rst is high; rst overrides every other event in that cycle.
//  FSM, 2 states:
//   - IDLE: in_ready=1, ser_valid=0. On in_valid, capture in_data into byte_reg, load idx with the first index, go to SHIFT.
//   - SHIFT: ser_valid=1, busy=1, ser_out=byte_reg[idx] via the mux. On a ser_valid&ser_ready beat, idx steps +1 (LSB_FIRST) or -1.
//   - ser_last=1 when idx is the final index (7 if LSB_FIRST, else 0).
//   - Accepted beat with ser_last=1: byte done; go to IDLE unless a new byte is captured in the same cycle.
//  Latency: byte captured at edge N; its first bit is valid in cycle N+1. With ser_ready held high, 8 bits occupy cycles N+1..N+8.
//  Back-to-back: in SHIFT, in_ready = ser_last & ser_ready (combinational from ser_ready).
//   - If in_valid is also high, the next byte loads and idx reloads on that same edge; state stays SHIFT.
//   - Result: zero idle cycles between bytes.
//  Backpressure: while ser_ready=0, ser_out/ser_last/idx/byte_reg hold. in_data changes after capture have no effect.
//  in_valid=1 during SHIFT (not the last accepted beat): in_ready=0, producer must hold; no capture.
//  Index arithmetic is 3-bit. No wrap past the final index, because the byte always ends there.
//  Reset mid-byte: the partial byte is discarded, no further bits are emitted, and the next byte starts at the first index.
// STRUCTURE
//  - Shared header serial_defs.vh: BYTE_W=8, IDX_W=3, state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1.
//  - One sub-module: mux8to1 (existing 8:1 bit mux). data_in=byte_reg, sel=idx, data_out feeds ser_out.
//  - Top level holds the FSM, idx counter, byte_reg and the handshake logic. ser_out gated to IDLE_LEVEL when ser_valid=0.
// TESTING
//  1. rst=1 for 2 cycles with in_valid=1 -> in_ready=0, ser_valid=0, busy=0, ser_out=IDLE_LEVEL; no capture afterwards.
//  2. LSB_FIRST=1, ser_ready=1, send 8'hA5 -> ser_out=1,0,1,0,0,1,0,1 in 8 consecutive cycles; ser_last only on the 8th; then IDLE.
//  3. Send 8'hA5, drop ser_ready for 3 cycles while idx=2 -> ser_out holds 1 and idx stays 2; resumes with bit3=0.
//  4. in_valid held with 8'hFF then 8'h00, ser_ready=1 -> 16 consecutive ser_valid cycles (8 ones, 8 zeros); in_ready pulses on cycle 8.
//  5. rst asserted while idx=4 -> next cycle ser_valid=0, busy=0; next byte 8'h01 starts with bit0=1.
//  6. LSB_FIRST=0, send 8'h80 -> ser_out=1 then seven 0s; ser_last with idx=0.

Source files
------------

// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared widths and FSM state encoding for the byte serializer
package byte_serializer_pkg;
    localparam int BYTE_W = 8;
    localparam int IDX_W  = 3;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/byte_serializer_mux8to1.sv
// mux8to1: 8:1 bit mux selecting data_in_i[sel_i]
//   data_in_i  [BYTE_W] byte to pick a bit from
//   sel_i      [IDX_W]  bit index
//   data_out_o [1]      selected bit
module mux8to1
    import byte_serializer_pkg::*;
(
    input  logic [BYTE_W-1:0] data_in_i,
    input  logic [IDX_W-1:0]  sel_i,
    output logic              data_out_o
);
    assign data_out_o = data_in_i[sel_i];
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: valid/ready byte-to-bitstream converter, one bit per accepted beat
//   clk, rst     clock, synchronous active-high reset
//   in_data_i    parallel byte          in_valid_i / in_ready_o   byte handshake
//   ser_out_o    serial bit             ser_valid_o / ser_ready_i bit handshake
//   ser_last_o   8th bit of the byte    busy_o                    FSM in SHIFT
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              ser_out_o,
    output logic              ser_valid_o,
    input  logic              ser_ready_i,
    output logic              ser_last_o,
    output logic              busy_o
);
    localparam logic [IDX_W-1:0] FIRST_IDX = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [IDX_W-1:0] LAST_IDX  = LSB_FIRST ? 3'd7 : 3'd0;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mux_bit, beat, load;

    mux8to1 u_mux (
        .data_in_i  (byte_q),
        .sel_i      (idx_q),
        .data_out_o (mux_bit)
    );

    assign ser_valid_o = state_q == ST_SHIFT;
    assign busy_o      = ser_valid_o;
    assign ser_last_o  = ser_valid_o && idx_q == LAST_IDX;
    assign ser_out_o   = ser_valid_o ? mux_bit : IDLE_LEVEL;
    assign beat        = ser_valid_o && ser_ready_i;
    // A new byte may be taken while the final bit is being consumed, giving zero-gap streaming.
    assign in_ready_o  = !rst && (state_q == ST_IDLE || (ser_last_o && ser_ready_i));
    assign load        = in_valid_i && in_ready_o;

    always_comb begin
        state_d = load ? ST_SHIFT : (beat && ser_last_o) ? ST_IDLE : state_q;
        byte_d  = load ? in_data_i : byte_q;
        idx_d   = load ? FIRST_IDX
                : (beat && !ser_last_o) ? (LSB_FIRST ? idx_q + 1'b1 : idx_q - 1'b1)
                : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed self-checking bench for byte_serializer (LSB-first and MSB-first instances)
module tb_byte_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h3C;
    logic       in_valid = 1'b1;
    logic       ser_ready = 1'b1;
    logic       in_ready, ser_out, ser_valid, ser_last, busy;
    logic       m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] pat;

    always #5 clk = ~clk;

    byte_serializer dut (
        .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ser_out_o(ser_out), .ser_valid_o(ser_valid), .ser_ready_i(ser_ready),
        .ser_last_o(ser_last), .busy_o(busy)
    );

    byte_serializer #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(m_in_ready),
        .ser_out_o(m_ser_out), .ser_valid_o(m_ser_valid), .ser_ready_i(ser_ready),
        .ser_last_o(m_ser_last), .busy_o(m_busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two edges with in_valid high
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_m_ser_out", m_ser_out, 1);
        chk("rst_m_in_ready", m_in_ready, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        chk("no_capture", ser_valid, 0);
        // A5 LSB first, ser_ready high
        pat = 8'hA5;
        in_data = pat;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_bit%0d", i), ser_out, pat[i]);
            chk($sformatf("a5_valid%0d", i), ser_valid, 1);
            chk($sformatf("a5_last%0d", i), ser_last, i == 7);
            chk($sformatf("a5_busy%0d", i), busy, 1);
            chk($sformatf("a5_rdy%0d", i), in_ready, i == 7);
            tick();
        end
        chk("a5_idle_valid", ser_valid, 0);
        chk("a5_idle_busy", busy, 0);
        chk("a5_idle_rdy", in_ready, 1);
        // backpressure at idx 2
        in_data = pat;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = 8'h00;
        tick();
        tick();
        ser_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_out%0d", i), ser_out, 1);
            chk($sformatf("bp_idx%0d", i), dut.idx_q, 2);
            chk($sformatf("bp_rdy%0d", i), in_ready, 0);
            chk($sformatf("bp_last%0d", i), ser_last, 0);
            tick();
        end
        ser_ready = 1'b1;
        #1;
        chk("bp_resume_idx", dut.idx_q, 2);
        chk("bp_resume_out", ser_out, 1);
        tick();
        for (int j = 3; j < 8; j++) begin
            chk($sformatf("bp_bit%0d", j), ser_out, pat[j]);
            chk($sformatf("bp_idx%0d", j), dut.idx_q, 8'(j));
            tick();
        end
        chk("bp_idle", ser_valid, 0);
        // back-to-back FF then 00
        in_data = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) in_valid = 1'b0;
            #1;
            chk($sformatf("b2b_valid%0d", k), ser_valid, 1);
            chk($sformatf("b2b_out%0d", k), ser_out, k < 8);
            chk($sformatf("b2b_rdy%0d", k), in_ready, k == 7 || k == 15);
            chk($sformatf("b2b_last%0d", k), ser_last, k == 7 || k == 15);
            tick();
        end
        chk("b2b_idle", ser_valid, 0);
        // reset mid-byte at idx 4
        in_data = 8'hF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_idx4", dut.idx_q, 4);
        chk("mid_out", ser_out, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_valid", ser_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_out_idle", ser_out, 0);
        in_data = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_new_bit0", ser_out, 1);
        chk("mid_new_valid", ser_valid, 1);
        tick();
        chk("mid_new_bit1", ser_out, 0);
        repeat (7) tick();
        chk("mid_new_idle", ser_valid, 0);
        // MSB-first instance, 80
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data = 8'h80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("msb_out%0d", k), m_ser_out, k == 0);
            chk($sformatf("msb_last%0d", k), m_ser_last, k == 7);
            chk($sformatf("msb_idx%0d", k), dut_m.idx_q, 8'(7 - k));
            chk($sformatf("msb_busy%0d", k), m_busy, 1);
            tick();
        end
        chk("msb_idle_valid", m_ser_valid, 0);
        chk("msb_idle_out", m_ser_out, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
